// File: rtl/demux_1to32_capture.sv
// rtl/demux_1to32_capture.sv - 1-to-32 bit-stream demux into a capture register
// Optional per-write one-hot strobe output is enabled by defining DEMUX32_STROBE_EN.
module demux_1to32_capture #(
    parameter logic [31:0] INIT_VAL = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        din,
    input  logic        din_valid,
    input  logic [4:0]  sel,
    input  logic        auto,
    output logic [31:0] dout,
    output logic        dout_valid,
    output logic        frame_done,
    output logic        busy,
    output logic [4:0]  ptr
`ifdef DEMUX32_STROBE_EN
    ,
    output logic [31:0] strobe
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] dout_q, dout_d;
    logic [31:0] wmask_q, wmask_d;
    logic [4:0]  ptr_q, ptr_d;
    logic        dout_valid_q, dout_valid_d;
    logic        frame_done_q, frame_done_d;
    logic        busy_q, busy_d;
    logic [31:0] strobe_q, strobe_d;

    logic [4:0]  target;
    logic [31:0] target_oh;
    logic        wr_en;

    assign target    = auto ? ptr_q : sel;
    assign target_oh = 32'd1 << target;
    // start wins over any beat presented in the same cycle
    assign wr_en     = (state_q == ST_FILL) && din_valid && !start;

    always_comb begin
        state_d      = state_q;
        dout_d       = dout_q;
        wmask_d      = wmask_q;
        ptr_d        = ptr_q;
        dout_valid_d = dout_valid_q;
        frame_done_d = 1'b0;
        strobe_d     = 32'd0;

        if (start) begin
            state_d      = ST_FILL;
            dout_d       = INIT_VAL;
            wmask_d      = 32'd0;
            ptr_d        = 5'd0;
            dout_valid_d = 1'b0;
        end else if (wr_en) begin
            dout_d   = (dout_q & ~target_oh) | (din ? target_oh : 32'd0);
            wmask_d  = wmask_q | target_oh;
            strobe_d = target_oh;
            if (auto) begin
                ptr_d = ptr_q + 5'd1;
            end
            if (&wmask_d) begin
                state_d      = ST_HOLD;
                dout_valid_d = 1'b1;
                frame_done_d = 1'b1;
            end
        end

        busy_d = (state_d == ST_FILL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            dout_q       <= INIT_VAL;
            wmask_q      <= 32'd0;
            ptr_q        <= 5'd0;
            dout_valid_q <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
            strobe_q     <= 32'd0;
        end else begin
            state_q      <= state_d;
            dout_q       <= dout_d;
            wmask_q      <= wmask_d;
            ptr_q        <= ptr_d;
            dout_valid_q <= dout_valid_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
            strobe_q     <= strobe_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign frame_done = frame_done_q;
    assign busy       = busy_q;
    assign ptr        = ptr_q;

`ifdef DEMUX32_STROBE_EN
    assign strobe = strobe_q;
`else
    logic unused_strobe;
    assign unused_strobe = ^strobe_q;
`endif

endmodule

// File: tb/tb_demux_1to32_capture.sv
// tb/tb_demux_1to32_capture.sv - self-checking bench for demux_1to32_capture
module tb_demux_1to32_capture;

    localparam logic [31:0] INIT = 32'h5A5A_0F0F;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        din = 1'b0;
    logic        din_valid = 1'b0;
    logic [4:0]  sel = 5'd0;
    logic        auto = 1'b0;
    logic [31:0] dout;
    logic        dout_valid;
    logic        frame_done;
    logic        busy;
    logic [4:0]  ptr;
`ifdef DEMUX32_STROBE_EN
    logic [31:0] strobe;
`endif

    demux_1to32_capture #(.INIT_VAL(INIT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .din        (din),
        .din_valid  (din_valid),
        .sel        (sel),
        .auto       (auto),
        .dout       (dout),
        .dout_valid (dout_valid),
        .frame_done (frame_done),
        .busy       (busy),
        .ptr        (ptr)
`ifdef DEMUX32_STROBE_EN
        ,
        .strobe     (strobe)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Reference model: a frame is a set of distinct slots; complete when 32 are seen.
    logic [31:0] m_dout;
    bit          m_written [32];
    int          m_count;
    bit          m_fill;
    bit          m_valid;
    bit          m_done;
    int          m_ptr;
    logic [31:0] m_strobe;

    task automatic model_reset();
        m_dout = INIT;
        foreach (m_written[i]) m_written[i] = 1'b0;
        m_count = 0;
        m_fill = 1'b0;
        m_valid = 1'b0;
        m_done = 1'b0;
        m_ptr = 0;
        m_strobe = 32'd0;
    endtask

    task automatic model_step();
        int t;
        m_done = 1'b0;
        m_strobe = 32'd0;
        if (start) begin
            m_dout = INIT;
            foreach (m_written[i]) m_written[i] = 1'b0;
            m_count = 0;
            m_fill = 1'b1;
            m_valid = 1'b0;
            m_ptr = 0;
        end else if (m_fill && din_valid) begin
            t = auto ? m_ptr : int'(sel);
            m_dout[t] = din;
            if (!m_written[t]) begin
                m_written[t] = 1'b1;
                m_count++;
            end
            if (auto) m_ptr = (m_ptr + 1) % 32;
            m_strobe = 32'd0;
            m_strobe[t] = 1'b1;
            if (m_count == 32) begin
                m_fill = 1'b0;
                m_valid = 1'b1;
                m_done = 1'b1;
            end
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic check_all(input string nm);
        chk({nm, ".dout"}, dout, m_dout);
        chk({nm, ".dout_valid"}, 32'(dout_valid), 32'(m_valid));
        chk({nm, ".frame_done"}, 32'(frame_done), 32'(m_done));
        chk({nm, ".busy"}, 32'(busy), 32'(m_fill));
        chk({nm, ".ptr"}, 32'(ptr), 32'(m_ptr));
`ifdef DEMUX32_STROBE_EN
        chk({nm, ".strobe"}, strobe, m_strobe);
`endif
    endtask

    // Drive at negedge, clock, update model, sample at the next negedge.
    task automatic cyc(input bit s, input bit dv, input bit d, input logic [4:0] sl, input bit au);
        start = s;
        din_valid = dv;
        din = d;
        sel = sl;
        auto = au;
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    typedef struct {
        bit          s;
        bit          dv;
        bit          d;
        logic [4:0]  sl;
        logic [31:0] e_dout;
        bit          e_busy;
        bit          e_valid;
        bit          e_done;
    } vec_t;

    vec_t tbl [35];

    initial begin
        logic [31:0] e;
        logic [31:0] pat;
        logic [31:0] held;
        int          pulses;

        // Select-mode frame with a duplicate write to slot 31.
        e = INIT;
        tbl[0] = '{s: 1'b1, dv: 1'b0, d: 1'b0, sl: 5'd0, e_dout: e, e_busy: 1'b1, e_valid: 1'b0, e_done: 1'b0};
        e[31] = 1'b1;
        tbl[1] = '{s: 1'b0, dv: 1'b1, d: 1'b1, sl: 5'd31, e_dout: e, e_busy: 1'b1, e_valid: 1'b0, e_done: 1'b0};
        e[31] = 1'b0;
        tbl[2] = '{s: 1'b0, dv: 1'b1, d: 1'b0, sl: 5'd31, e_dout: e, e_busy: 1'b1, e_valid: 1'b0, e_done: 1'b0};
        for (int k = 0; k < 31; k++) begin
            e[k] = 1'b1;
            tbl[3+k] = '{s: 1'b0, dv: 1'b1, d: 1'b1, sl: 5'(k), e_dout: e,
                         e_busy: (k != 30), e_valid: (k == 30), e_done: (k == 30)};
        end
        tbl[34] = '{s: 1'b0, dv: 1'b0, d: 1'b0, sl: 5'd0, e_dout: e, e_busy: 1'b0, e_valid: 1'b1, e_done: 1'b0};

        model_reset();
        #12;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // IDLE ignores beats
        cyc(0, 1, 1, 5'd3, 0);
        check_all("idle_ignore");

        // Auto fill with a fixed pattern, LSB first
        pat = 32'hA5C3_0F96;
        pulses = 0;
        cyc(1, 0, 0, 5'd0, 1);
        check_all("auto_start");
        for (int i = 0; i < 32; i++) begin
            cyc(0, 1, pat[i], 5'($urandom), 1);
            check_all("auto_beat");
            if (frame_done) pulses++;
        end
        chk("auto_final_dout", dout, 32'hA5C3_0F96);
        chk("auto_final_ptr", 32'(ptr), 32'd0);
        chk("auto_final_busy", 32'(busy), 32'd0);
        chk("auto_final_valid", 32'(dout_valid), 32'd1);

        // HOLD freeze
        held = dout;
        for (int i = 0; i < 10; i++) begin
            cyc(0, 1, 1'($urandom), 5'($urandom), 1'($urandom));
            check_all("hold_beat");
            if (frame_done) pulses++;
        end
        chk("hold_frame_done_pulses", 32'(pulses), 32'd1);
        chk("hold_frozen", dout, held);

        // Restart from HOLD
        cyc(1, 0, 0, 5'd0, 0);
        check_all("restart");
        chk("restart_dout", dout, INIT);
        chk("restart_valid", 32'(dout_valid), 32'd0);

        // Start priority: coincident beat is discarded
        cyc(1, 1, 1, 5'd0, 0);
        check_all("start_prio");
        chk("start_prio_bit0", 32'(dout[0]), 32'(INIT[0]));
        chk("start_prio_busy", 32'(busy), 32'd1);
        // slot 0 was not counted: 31 other slots must not complete the frame
        for (int k = 1; k < 32; k++) cyc(0, 1, 1, 5'(k), 0);
        check_all("start_prio_no_done");
        chk("start_prio_still_busy", 32'(busy), 32'd1);
        cyc(0, 1, 0, 5'd0, 0);
        check_all("start_prio_done");

        // Table-driven select-mode sequence
        for (int i = 0; i < 35; i++) begin
            cyc(tbl[i].s, tbl[i].dv, tbl[i].d, tbl[i].sl, 1'b0);
            chk($sformatf("tbl[%0d].dout", i), dout, tbl[i].e_dout);
            chk($sformatf("tbl[%0d].busy", i), 32'(busy), 32'(tbl[i].e_busy));
            chk($sformatf("tbl[%0d].valid", i), 32'(dout_valid), 32'(tbl[i].e_valid));
            chk($sformatf("tbl[%0d].done", i), 32'(frame_done), 32'(tbl[i].e_done));
            chk($sformatf("tbl[%0d].ptr", i), 32'(ptr), 32'd0);
        end
        chk("sel_final", dout, 32'h7FFF_FFFF);

        // Back-to-back: start in the frame_done cycle
        cyc(1, 0, 0, 5'd0, 1);
        for (int i = 0; i < 32; i++) cyc(0, 1, 1'($urandom), 5'd0, 1);
        chk("b2b_done_high", 32'(frame_done), 32'd1);
        cyc(1, 0, 0, 5'd0, 1);
        check_all("b2b_restart");
        chk("b2b_done_low", 32'(frame_done), 32'd0);
        chk("b2b_valid_low", 32'(dout_valid), 32'd0);

`ifdef DEMUX32_STROBE_EN
        for (int i = 0; i < 5; i++) cyc(0, 1, 1, 5'd0, 1);
        cyc(0, 1, 1, 5'd9, 1);
        chk("strobe_ptr5", strobe, 32'h0000_0020);
        cyc(0, 0, 0, 5'd0, 1);
        chk("strobe_clear", strobe, 32'd0);
        cyc(1, 1, 1, 5'd0, 0);
        chk("strobe_start_discard", strobe, 32'd0);
`endif

        // Async reset mid-frame after 17 writes
        cyc(1, 0, 0, 5'd0, 1);
        for (int i = 0; i < 17; i++) cyc(0, 1, 1'($urandom), 5'd0, 1);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("async_reset");
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 1, 5'd0, 1);
            check_all("in_reset");
        end
        rst_n = 1'b1;
        cyc(0, 1, 1, 5'd0, 1);
        check_all("post_reset_idle");

        // Randomized mixed-mode traffic against the model
        for (int i = 0; i < 3000; i++) begin
            bit s;
            s = m_fill ? ($urandom_range(0, 299) == 0) : ($urandom_range(0, 19) == 0);
            if (m_done && $urandom_range(0, 1) == 1) s = 1'b1;
            cyc(s, ($urandom_range(0, 3) != 0), 1'($urandom), 5'($urandom),
                ($urandom_range(0, 3) != 0));
            check_all("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/demux_1to32_capture.md
# demux_1to32_capture

Sequential 1-to-32 demultiplexer that routes a single-bit input stream into a 32-bit capture register, one addressed slot per valid beat. It performs the inverse of the counter datapath's 32-to-1 selection tree: it distributes bits to 32 destinations, either under explicit 5-bit select or from an internal wrapping slot pointer. Frame-complete status is reported once every slot has been written since the last start.

## Interface
- `INIT_VAL`, default `32'h0000_0000`: value loaded into `dout` at reset and on every accepted `start`.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: clears the capture state and begins a frame; highest priority.
- `din` in 1: data bit to route.
- `din_valid` in 1: `din` is valid this cycle.
- `sel` in 5: target slot in select mode; ignored in auto mode.
- `auto` in 1: 1 routes to internal `ptr`, 0 routes to `sel`; sampled on each write.
- `dout` out 32: capture register.
- `dout_valid` out 1: level; all 32 slots written since the last `start`.
- `frame_done` out 1: one-cycle pulse when the frame completes.
- `busy` out 1: high while in FILL.
- `ptr` out 5: internal slot pointer.
- `strobe` out 32: present only with `DEMUX32_STROBE_EN`.

## Operation
- Internal state:
  - FSM with states IDLE, FILL, HOLD.
  - 32-bit written mask `wmask`.
  - 5-bit `ptr`.
- Reset (async, `rst_n`=0):
  - FSM = IDLE, `dout`=`INIT_VAL`, `wmask`=0, `ptr`=0.
  - `dout_valid`=0, `frame_done`=0, `busy`=0, `strobe`=0.
- `start`=1 in any state:
  - `dout`←`INIT_VAL`, `wmask`←0, `ptr`←0, `dout_valid`←0, FSM→FILL.
  - A `din_valid` beat in the same cycle is discarded.
- IDLE: `din_valid` is ignored.
- FILL, on each `din_valid`=1 without `start`:
  - Target t = `auto` ? `ptr` : `sel`.
  - `dout[t]`←`din`; `wmask[t]`←1.
  - If `auto`=1, `ptr`←`ptr`+1, modulo 32 (31 wraps to 0).
  - If `auto`=0, `ptr` holds.
- Rewriting an already-written slot overwrites that bit and does not advance completion.
- Modes may be mixed within a frame. `ptr` advances only on auto-mode writes.
- Completion: if (`wmask` | onehot(t)) == all ones on a write:
  - FSM→HOLD, `dout_valid`←1, `frame_done`←1 for exactly one cycle.
- HOLD:
  - `dout` is frozen and `din_valid` is ignored.
  - `dout_valid` stays 1 until the next `start` or reset.
- `busy` = (FSM==FILL), registered.

## Timing
- Write latency: `din` sampled at edge N is visible on `dout[t]` after edge N; 1 cycle.
- `frame_done` and `dout_valid` rise after the same edge that captures the final slot.
- `frame_done` falls after the following edge.
- `start` at edge N: `busy`=1 and `dout`=`INIT_VAL` after edge N. The earliest accepted write is at edge N+1.
- Minimum frame: 32 consecutive `din_valid` cycles.
  - `frame_done` is high in cycle start+33, counting the start cycle as cycle 1.
- Back-to-back frames: `start` in the `frame_done` cycle restarts immediately and clears `dout_valid`. The `frame_done` pulse still ends after one cycle.
- Reset mid-frame: all state clears asynchronously; no `frame_done` is issued.
- No back-pressure: every `din_valid` in FILL is accepted.

## Configuration
- `DEMUX32_STROBE_EN` defined:
  - Port `strobe[31:0]` exists.
  - Registered one-hot of t, high for the one cycle following each accepted write and aligned with the `dout` update.
  - All-zero otherwise, including on `start`-discarded beats.
- `DEMUX32_STROBE_EN` undefined: `strobe` port and logic are absent; all other behaviour is identical.

## Test plan
- Reset then auto fill:
  - `start`, then 32 beats with `auto`=1, `din` pattern giving `32'hA5C3_0F96` (LSB first).
  - Expect `dout`=`32'hA5C3_0F96`, `frame_done` for exactly 1 cycle, `dout_valid`=1, `ptr`=0 (wrapped), `busy`=0.
- Select mode with duplicate write:
  - `auto`=0, write `sel`=31 twice (1, then 0), then slots 0..30 with `din`=1.
  - Expect completion only after slot 30; final `dout`=`32'h7FFF_FFFF`.
- Start priority:
  - `start` with `din_valid`=1, `din`=1, `sel`=0 in the same cycle.
  - Expect `dout[0]`=`INIT_VAL[0]`, `wmask`=0, `busy`=1.
- HOLD freeze and restart:
  - After completion, drive 10 `din_valid` beats: `dout` unchanged.
  - Then `start`: `dout`=`INIT_VAL`, `dout_valid`=0 after 1 edge.
- Async reset mid-frame:
  - Assert `rst_n`=0 after 17 writes, off a clock edge.
  - Expect all outputs at reset values immediately and no `frame_done`.
- Strobe (with `DEMUX32_STROBE_EN`):
  - Auto write at `ptr`=5 → `strobe`=`32'h0000_0020` for one cycle.
  - Discarded beat under `start` → `strobe`=0.
